// File: rtl/beat_timer.sv
// Machine-beat generator: produces one-hot W1/W2/W3 on the falling edge of T3.
// Cycle length follows SHORT/LONG, halts on STOP/SSTEP, and restarts on a synchronised QD rising edge.
module beat_timer #(
    parameter int QD_SYNC_STAGES = 2,
    parameter int CYC_W          = 16
) (
    input  logic             T3,
    input  logic             CLR,
    input  logic             QD,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    input  logic             SSTEP,
    output logic             W1,
    output logic             W2,
    output logic             W3,
    output logic             RUN,
    output logic             T_END,
    output logic [CYC_W-1:0] CYC_CNT
);

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

    logic [QD_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                      prev_q;
    logic                      run_q, run_d;
    logic [2:0]                w_q, w_d;
    logic [CYC_W-1:0]          cyc_q, cyc_d;
    logic                      qd_rise;
    logic                      end_beat;

    assign sync_d   = {sync_q[QD_SYNC_STAGES-2:0], QD};
    assign qd_rise  = sync_q[QD_SYNC_STAGES-1] & ~prev_q;
    assign end_beat = (w_q[0] & SHORT) | (w_q[1] & ~LONG) | w_q[2];

    always_comb begin
        run_d = run_q;
        w_d   = w_q;
        cyc_d = cyc_q;
        if (!run_q) begin
            // A rise that lands on the halting edge is consumed by prev_q and never seen here.
            if (qd_rise) begin
                run_d = 1'b1;
                w_d   = 3'b001;
            end
        end else if (end_beat) begin
            if (cyc_q != CYC_MAX) begin
                cyc_d = cyc_q + CYC_ONE;
            end
            if (STOP || SSTEP) begin
                run_d = 1'b0;
            end else begin
                w_d = 3'b001;
            end
        end else begin
            w_d = {w_q[1:0], 1'b0};
        end
    end

    always_ff @(negedge T3 or posedge CLR) begin
        if (CLR) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            run_q  <= 1'b0;
            w_q    <= 3'b000;
            cyc_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[QD_SYNC_STAGES-1];
            run_q  <= run_d;
            w_q    <= w_d;
            cyc_q  <= cyc_d;
        end
    end

    assign W1      = w_q[0];
    assign W2      = w_q[1];
    assign W3      = w_q[2];
    assign RUN     = run_q;
    assign T_END   = run_q & end_beat;
    assign CYC_CNT = cyc_q;

endmodule

// File: tb/tb_beat_timer.sv
// Randomised scoreboard bench for beat_timer: a driver predicts each falling-edge result
// from a beat-level model and queues it; a monitor pops and compares after every edge.
module tb_beat_timer;

    localparam int S = 2;

    logic        T3 = 1'b0;
    logic        CLR = 1'b1;
    logic        QD = 1'b0;
    logic        SHORT = 1'b0;
    logic        LONG = 1'b0;
    logic        STOP = 1'b0;
    logic        SSTEP = 1'b0;
    logic        W1, W2, W3, RUN, T_END;
    logic [15:0] CYC_CNT;
    logic        sW1, sW2, sW3, sRUN, sT_END;
    logic [3:0]  sCYC_CNT;

    beat_timer #(.QD_SYNC_STAGES(S), .CYC_W(16)) u_dut (
        .T3(T3), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP), .SSTEP(SSTEP),
        .W1(W1), .W2(W2), .W3(W3), .RUN(RUN), .T_END(T_END), .CYC_CNT(CYC_CNT)
    );

    beat_timer #(.QD_SYNC_STAGES(S), .CYC_W(4)) u_sat (
        .T3(T3), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP), .SSTEP(SSTEP),
        .W1(sW1), .W2(sW2), .W3(sW3), .RUN(sRUN), .T_END(sT_END), .CYC_CNT(sCYC_CNT)
    );

    always #5 T3 = ~T3;

    typedef struct {
        bit       run;
        bit [2:0] w;
        bit       tend;
        int       cnt16;
        int       cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    bit   active    = 1'b0;

    // Reference model: beat number 0..3 (0 = none yet), unbounded cycle count, QD delay line.
    bit   m_run;
    int   m_beat;
    int   m_cnt;
    bit   hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic bit is_end(input int beat, input bit sh, input bit lg);
        return (beat == 1 && sh) || (beat == 2 && !lg) || (beat == 3);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_beat = 0;
        m_cnt  = 0;
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
    endtask

    task automatic model_edge();
        exp_t e;
        bit   rise;
        if (CLR) begin
            model_reset();
        end else begin
            hist.push_front(QD);
            void'(hist.pop_back());
            rise = hist[S] && !hist[S+1];
            if (!m_run) begin
                if (rise) begin
                    m_run  = 1'b1;
                    m_beat = 1;
                end
            end else if (is_end(m_beat, SHORT, LONG)) begin
                m_cnt++;
                if (STOP || SSTEP) m_run = 1'b0;
                else m_beat = 1;
            end else begin
                m_beat++;
            end
        end
        e.run   = m_run;
        e.w     = (m_beat == 0) ? 3'b000 : 3'(1 << (m_beat - 1));
        e.tend  = m_run && is_end(m_beat, SHORT, LONG);
        e.cnt16 = (m_cnt > 65535) ? 65535 : m_cnt;
        e.cnt4  = (m_cnt > 15) ? 15 : m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_RUN"}, 32'(RUN), 32'd0);
        chk({tag, "_W"}, 32'({W3, W2, W1}), 32'd0);
        chk({tag, "_TEND"}, 32'(T_END), 32'd0);
        chk({tag, "_CNT"}, 32'(CYC_CNT), 32'd0);
        chk({tag, "_CNT4"}, 32'(sCYC_CNT), 32'd0);
    endtask

    task automatic cycle(input bit clr, input bit qd, input bit sh, input bit lg,
                         input bit st, input bit ss, input bit clr_mid);
        @(posedge T3);
        #1;
        CLR = clr; QD = qd; SHORT = sh; LONG = lg; STOP = st; SSTEP = ss;
        if (clr_mid) begin
            #1 CLR = 1'b1;
            #1 check_zero("ASYNC_CLR");
        end
        model_edge();
        active = 1'b1;
    endtask

    // Monitor: every falling edge yields one registered result to compare.
    initial begin : monitor
        exp_t me;
        forever begin
            @(negedge T3);
            #1;
            if (exp_q.size() == 0) begin
                if (active) chk("QUEUE_EMPTY", 32'd1, 32'd0);
            end else begin
                me = exp_q.pop_front();
                chk("RUN", 32'(RUN), 32'(me.run));
                chk("W", 32'({W3, W2, W1}), 32'(me.w));
                chk("T_END", 32'(T_END), 32'(me.tend));
                chk("CYC_CNT", 32'(CYC_CNT), me.cnt16);
                chk("CYC_CNT_SAT4", 32'(sCYC_CNT), me.cnt4);
            end
        end
    end

    initial begin : driver
        model_reset();
        #1 check_zero("RESET");
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Plain start: W1,W2 alternation.
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        // LONG-stretched cycles, and SHORT+LONG in W1.
        for (int i = 0; i < 20; i++) cycle(0, 0, i % 5 == 0, 1'($urandom_range(0, 1)), 0, 0, 0);
        // STOP held until halt, then QD held high for a single resume.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        // Single-step with SHORT: three QD pulses give three one-beat cycles.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0, 1, 0);
            for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 0, 1, 0);
        end
        // Free run long enough to saturate the 4-bit counter.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) cycle(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);
        // Abort mid-W3 asynchronously, then release with QD already high.
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        // Randomised soak including occasional STOP/SSTEP/QD activity and async clears.
        for (int i = 0; i < 500; i++) begin
            cycle(0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
        end
        @(negedge T3);
        #3;
        active = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
